// File: rtl/apa102_rx_if.sv
// Signal bundle between an APA102 LED-stream source and the frame decoder.
// The source drives the strip lines and the colour key; the decoder returns the decoded results.
interface apa102_rx_if;
    logic        sck;
    logic        sdi;
    logic [31:0] fg_word;
    logic [31:0] word;
    logic        word_valid;
    logic [5:0]  pixel_idx;
    logic [63:0] bitmap;
    logic        frame_done;
    logic        err;

    modport master (
        output sck, sdi, fg_word,
        input  word, word_valid, pixel_idx, bitmap, frame_done, err
    );

    modport slave (
        input  sck, sdi, fg_word,
        output word, word_valid, pixel_idx, bitmap, frame_done, err
    );
endinterface

// File: rtl/apa102_rx.sv
// Sniffs an APA102 LED strip stream and decodes each display frame into a per-pixel
// foreground bitmap. It resynchronises on a 32-zero start frame and aborts on bad headers or a stalled sck.
//
// state | meaning
// HUNT  | counting zero bits, waiting for a 1 after a 32-zero start frame
// PIXEL | shifting in 32-bit LED frames and classifying each pixel
module apa102_rx #(
    parameter int NPIX    = 64,
    parameter int SNAKE   = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    apa102_rx_if.slave  bus
);

    localparam int              IW        = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]   IDLE_LOAD = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0]   IDLE_ONE  = IW'(1);
    localparam logic [6:0]      LAST_PIX  = 7'(NPIX - 1);
    localparam logic [5:0]      ZERO_SAT  = 6'd32;

    typedef enum logic {HUNT, PIXEL} state_t;

    state_t      r_state, w_state_nxt;

    logic        r_sck_s1, r_sck_s2, r_sck_prev;
    logic        r_sdi_s1, r_sdi_s2;
    logic        w_rise;
    logic        w_bit;

    logic [5:0]  r_zero_cnt, w_zero_nxt;
    logic [31:0] r_shift, w_shift_nxt;
    logic [4:0]  r_bit_cnt, w_bit_nxt;
    logic        r_full, w_full_nxt;
    logic [6:0]  r_pix_cnt, w_pix_nxt;
    logic [IW-1:0] r_idle, w_idle_nxt;
    logic [63:0] r_work_bm, w_work_nxt;

    logic [31:0] r_word, w_word_nxt;
    logic [5:0]  r_pixel_idx, w_pidx_nxt;
    logic [63:0] r_bitmap, w_bitmap_nxt;
    logic        r_word_valid, w_wv_nxt;
    logic        r_frame_done, w_fd_nxt;
    logic        r_err, w_err_nxt;

    logic        w_hit;
    logic [5:0]  w_pos;
    logic [2:0]  w_row;
    logic [2:0]  w_col;

    assign w_rise = r_sck_s2 & ~r_sck_prev;
    assign w_bit  = r_sdi_s2;
    assign w_hit  = (r_shift == bus.fg_word);

    // Serpentine strips run even rows right-to-left; fold them back into raster order.
    always_comb begin
        w_row = r_pix_cnt[5:3];
        w_col = r_pix_cnt[2:0];
        w_pos = r_pix_cnt[5:0];
        if ((SNAKE != 0) && !w_row[0]) begin
            w_pos = {w_row, ~w_col};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sck_s1   <= 1'b0;
            r_sck_s2   <= 1'b0;
            r_sck_prev <= 1'b0;
            r_sdi_s1   <= 1'b0;
            r_sdi_s2   <= 1'b0;
        end else begin
            r_sck_s1   <= bus.sck;
            r_sck_s2   <= r_sck_s1;
            r_sck_prev <= r_sck_s2;
            r_sdi_s1   <= bus.sdi;
            r_sdi_s2   <= r_sdi_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= HUNT;
            r_zero_cnt   <= '0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_full       <= 1'b0;
            r_pix_cnt    <= '0;
            r_idle       <= '0;
            r_work_bm    <= '0;
            r_word       <= '0;
            r_pixel_idx  <= '0;
            r_bitmap     <= '0;
            r_word_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_zero_cnt   <= w_zero_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_full       <= w_full_nxt;
            r_pix_cnt    <= w_pix_nxt;
            r_idle       <= w_idle_nxt;
            r_work_bm    <= w_work_nxt;
            r_word       <= w_word_nxt;
            r_pixel_idx  <= w_pidx_nxt;
            r_bitmap     <= w_bitmap_nxt;
            r_word_valid <= w_wv_nxt;
            r_frame_done <= w_fd_nxt;
            r_err        <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_zero_nxt   = r_zero_cnt;
        w_shift_nxt  = r_shift;
        w_bit_nxt    = r_bit_cnt;
        w_full_nxt   = 1'b0;
        w_pix_nxt    = r_pix_cnt;
        w_idle_nxt   = r_idle;
        w_work_nxt   = r_work_bm;
        w_word_nxt   = r_word;
        w_pidx_nxt   = r_pixel_idx;
        w_bitmap_nxt = r_bitmap;
        w_wv_nxt     = 1'b0;
        w_fd_nxt     = 1'b0;
        w_err_nxt    = 1'b0;

        unique case (r_state)
            HUNT: begin
                if (w_rise) begin
                    if (!w_bit) begin
                        if (r_zero_cnt != ZERO_SAT) begin
                            w_zero_nxt = r_zero_cnt + 6'd1;
                        end
                    end else if (r_zero_cnt == ZERO_SAT) begin
                        // This 1 is the MSB of pixel 0's header, so it seeds the shift register.
                        w_state_nxt = PIXEL;
                        w_shift_nxt = 32'd1;
                        w_bit_nxt   = 5'd1;
                        w_pix_nxt   = '0;
                        w_idle_nxt  = IDLE_LOAD;
                        w_zero_nxt  = '0;
                    end else begin
                        w_zero_nxt  = '0;
                    end
                end
            end

            PIXEL: begin
                if (r_full) begin
                    w_word_nxt = r_shift;
                    w_pidx_nxt = r_pix_cnt[5:0];
                    w_wv_nxt   = 1'b1;
                    if (r_shift[31:29] != 3'b111) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = HUNT;
                        w_zero_nxt  = '0;
                        w_work_nxt  = '0;
                    end else begin
                        w_work_nxt[w_pos] = w_hit;
                        if (r_pix_cnt == LAST_PIX) begin
                            w_bitmap_nxt = w_work_nxt;
                            w_fd_nxt     = 1'b1;
                            w_state_nxt  = HUNT;
                            w_zero_nxt   = '0;
                            w_work_nxt   = '0;
                        end else begin
                            w_pix_nxt = r_pix_cnt + 7'd1;
                        end
                    end
                end else if (w_rise) begin
                    w_shift_nxt = {r_shift[30:0], w_bit};
                    w_bit_nxt   = r_bit_cnt + 5'd1;
                    w_idle_nxt  = IDLE_LOAD;
                    if (r_bit_cnt == 5'd31) begin
                        w_full_nxt = 1'b1;
                    end
                end else if (r_idle == '0) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = HUNT;
                    w_zero_nxt  = '0;
                    w_work_nxt  = '0;
                end else begin
                    w_idle_nxt = r_idle - IDLE_ONE;
                end
            end

            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    assign bus.word       = r_word;
    assign bus.pixel_idx  = r_pixel_idx;
    assign bus.bitmap     = r_bitmap;
    assign bus.word_valid = r_word_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_apa102_rx.sv
// Scoreboard bench for apa102_rx: one raster-order and one serpentine decoder share the same
// LED stream; expected strobes and bitmaps are queued by the stimulus and checked by a monitor.
module tb_apa102_rx;

    localparam int          TMO = 200;
    localparam logic [31:0] FG  = 32'hf000_0f00;
    localparam logic [31:0] BG  = 32'hf007_0000;
    localparam logic [31:0] BAD = 32'h00ff_00ff;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sck   = 1'b0;
    logic sdi   = 1'b0;

    always #5 clk = ~clk;

    apa102_rx_if bus0 ();
    apa102_rx_if bus1 ();

    assign bus0.sck     = sck;
    assign bus0.sdi     = sdi;
    assign bus0.fg_word = FG;
    assign bus1.sck     = sck;
    assign bus1.sdi     = sdi;
    assign bus1.fg_word = FG;

    apa102_rx #(.NPIX(64), .SNAKE(0), .TIMEOUT(TMO)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    apa102_rx #(.NPIX(64), .SNAKE(1), .TIMEOUT(TMO)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct packed {
        logic        wv;
        logic        err;
        logic        fd;
        logic [5:0]  idx;
        logic [31:0] word;
    } ev_t;

    ev_t         q_ev[$];
    logic [63:0] q_bm0[$];
    logic [63:0] q_bm1[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe from the raster decoder must match the head of the queue.
    always @(negedge clk) begin
        ev_t e_got;
        ev_t e_exp;
        if (bus0.word_valid || bus0.err || bus0.frame_done) begin
            e_got = '{wv: bus0.word_valid, err: bus0.err, fd: bus0.frame_done,
                      idx: bus0.pixel_idx, word: bus0.word};
            if (q_ev.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_event: got %h expected none", e_got);
            end else begin
                e_exp = q_ev.pop_front();
                if (!e_exp.wv) begin
                    e_got.idx  = '0;
                    e_got.word = '0;
                end
                check("event", 64'(e_got), 64'(e_exp));
            end
            if (bus0.frame_done) begin
                if (q_bm0.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_frame_done0: got %h expected none", bus0.bitmap);
                end else begin
                    check("bitmap_raster", bus0.bitmap, q_bm0.pop_front());
                end
            end
        end
        if (bus1.frame_done) begin
            if (q_bm1.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_frame_done1: got %h expected none", bus1.bitmap);
            end else begin
                check("bitmap_snake", bus1.bitmap, q_bm1.pop_front());
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        sck = 1'b0;
        sdi = b;
        @(negedge clk);
        @(negedge clk);
        sck = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_zeros(input int n);
        repeat (n) send_bit(1'b0);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    // kind 0: fg on even words; kind 1: fg on word 0 only; kind 2: kind 0 with a bad header at word 5
    function automatic logic [31:0] pix_word(input int kind, input int i);
        if (kind == 1) return (i == 0) ? FG : BG;
        if (kind == 2 && i == 5) return BAD;
        return (i % 2 == 0) ? FG : BG;
    endfunction

    task automatic stream_frame(input int kind, input int nwords, input bit tail);
        logic [31:0] w;
        send_zeros(32);
        for (int i = 0; i < nwords; i++) begin
            w = pix_word(kind, i);
            if (!(kind == 2 && i > 5)) begin
                q_ev.push_back('{wv: 1'b1, err: (kind == 2 && i == 5), fd: (kind != 2 && i == 63),
                                 idx: 6'(i), word: w});
            end
            send_word(w);
        end
        if (tail) send_zeros(64);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_word"},       64'(bus0.word),       64'd0);
        check({tag, "_pixel_idx"},  64'(bus0.pixel_idx),  64'd0);
        check({tag, "_bitmap0"},    bus0.bitmap,          64'd0);
        check({tag, "_bitmap1"},    bus1.bitmap,          64'd0);
        check({tag, "_word_valid"}, 64'(bus0.word_valid), 64'd0);
        check({tag, "_frame_done"}, 64'(bus0.frame_done), 64'd0);
        check({tag, "_err"},        64'(bus0.err),        64'd0);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;

        // 31 zeros are not a start frame: the word that follows must be ignored
        send_zeros(31);
        send_word(FG);
        send_zeros(8);

        q_bm0.push_back(64'h5555_5555_5555_5555);
        q_bm1.push_back(64'h55AA_55AA_55AA_55AA);
        stream_frame(0, 64, 1'b1);

        q_bm0.push_back(64'h0000_0000_0000_0001);
        q_bm1.push_back(64'h0000_0000_0000_0080);
        stream_frame(1, 64, 1'b1);

        stream_frame(2, 64, 1'b1);
        check("bitmap0_after_hdr_err", bus0.bitmap, 64'h0000_0000_0000_0001);
        check("bitmap1_after_hdr_err", bus1.bitmap, 64'h0000_0000_0000_0080);

        // sck stalls after pixel 10
        stream_frame(0, 11, 1'b0);
        q_ev.push_back('{wv: 1'b0, err: 1'b1, fd: 1'b0, idx: 6'd0, word: 32'd0});
        @(negedge clk);
        sck = 1'b0;
        repeat (TMO + 40) @(negedge clk);
        check("timeout_err_seen", 64'(q_ev.size()), 64'd0);
        check("bitmap0_after_timeout", bus0.bitmap, 64'h0000_0000_0000_0001);

        q_bm0.push_back(64'h5555_5555_5555_5555);
        q_bm1.push_back(64'h55AA_55AA_55AA_55AA);
        stream_frame(0, 64, 1'b1);

        // reset in the middle of pixel 40
        stream_frame(0, 40, 1'b0);
        for (int i = 31; i >= 16; i--) send_bit(FG[i]);
        @(negedge clk);
        sck   = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("midframe_reset");
        reset = 1'b0;

        q_bm0.push_back(64'h0000_0000_0000_0001);
        q_bm1.push_back(64'h0000_0000_0000_0080);
        stream_frame(1, 64, 1'b1);

        repeat (20) @(negedge clk);
        check("pending_events", 64'(q_ev.size()), 64'd0);
        check("pending_bitmap0", 64'(q_bm0.size()), 64'd0);
        check("pending_bitmap1", 64'(q_bm1.size()), 64'd0);

        summary();
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got no completion expected completion within 2 ms");
        summary();
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apa102_rx.md
APA102_RX -- requirements
Module: apa102_rx

Interface
REQ-001 Parameter NPIX, default 64: number of 32-bit LED frames in one display frame (8x8 matrix).
REQ-002 Parameter SNAKE, default 1: when 1, undo serpentine row ordering when building bitmap; when 0, bitmap index = stream index.
REQ-003 Parameter TIMEOUT, default 4096: clk cycles without an sck rising edge before an in-progress frame is aborted.
REQ-004 clk  input  1  system clock, at least 4x the sck frequency.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 sck  input  1  LED strip serial clock, asynchronous to clk.
REQ-007 sdi  input  1  LED strip serial data, asynchronous to clk, valid at the sck rising edge.
REQ-008 fg_word  input  32  foreground colour word used to classify pixels.
REQ-009 word  output  32  last received LED frame, MSB first as shifted in.
REQ-010 word_valid  output  1  one-cycle strobe: word and pixel_idx are valid.
REQ-011 pixel_idx  output  6  stream index (0..NPIX-1) of word.
REQ-012 bitmap  output  64  per-pixel foreground map of the last complete frame.
REQ-013 frame_done  output  1  one-cycle strobe: bitmap updated.
REQ-014 err  output  1  one-cycle strobe: header error or timeout abort.

Function
REQ-015 sck and sdi SHALL each pass through a 2-flop synchronizer. An sck rising edge SHALL be detected from synchronized sck (prev 0, now 1). sdi SHALL be sampled from its synchronized value in the same clk cycle.
REQ-016 FSM states SHALL be HUNT and PIXEL. Reset state: HUNT.
REQ-017 HUNT, sampled bit 0: zero counter (6 bits) increments, saturating at 32.
REQ-018 HUNT, sampled bit 1 with zero counter = 32 (start frame seen): enter PIXEL with shift register = 1, bit counter = 1, pixel counter = 0.
REQ-019 HUNT, sampled bit 1 with zero counter < 32: zero counter clears to 0; state stays HUNT.
REQ-020 PIXEL: each sampled bit SHALL shift into the 32-bit shift register LSB, and the bit counter SHALL increment.
REQ-021 On the 32nd bit, in the following clk cycle: word = assembled value; pixel_idx = pixel counter; word_valid = 1 for exactly one cycle; bit counter clears.
REQ-022 Header check: if assembled[31:29] != 3'b111, err SHALL pulse in the same cycle as word_valid. The FSM SHALL return to HUNT with zero counter 0, and the working bitmap SHALL be discarded.
REQ-023 Valid header: working bitmap bit p SHALL be set to (assembled == fg_word), and the pixel counter SHALL increment. p = pixel counter if SNAKE=0. If SNAKE=1, with row = idx/8 and col = idx%8: p = row*8 + (7 - col) for even rows, and p = idx for odd rows.
REQ-024 After pixel NPIX-1 with a valid header: bitmap = working bitmap (including the final bit); frame_done = 1 for one cycle, coincident with that word_valid; FSM returns to HUNT with zero counter 0; working bitmap clears.
REQ-025 End-frame and inter-frame zero bits SHALL be absorbed by HUNT and SHALL produce no strobes.
REQ-026 PIXEL idle counter SHALL reset on every sck rising edge. On reaching TIMEOUT: err pulses, FSM returns to HUNT with zero counter 0, working bitmap discards, no word_valid is issued.
REQ-027 bitmap SHALL change only at frame_done or reset. word and pixel_idx SHALL hold between strobes.
REQ-028 word_valid and err in the same cycle are legal only per REQ-022. frame_done never coincides with err.

Reset
REQ-029 While reset is high at a clk edge, the block SHALL load: state HUNT; all counters, shift register and synchronizers 0; word, pixel_idx, bitmap, word_valid, frame_done, err 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no strobes. After release, a full 32-zero start frame is required before capture.

Verification
REQ-031 Bench SHALL cover: fg_word=32'hf0000f00. Stream 32 zeros, 64 words alternating f0000f00/f0070000, then 64 zeros. Required: 64 word_valid strobes with pixel_idx 0..63, one frame_done, and with SNAKE=0 bitmap=64'h5555_5555_5555_5555.
REQ-032 Bench SHALL cover: the same frame with SNAKE=1, only stream word 0 = fg. Required: bitmap bit 7 set, all others clear.
REQ-033 Bench SHALL cover: only 31 zeros, then a word. Required: no word_valid, FSM remains HUNT.
REQ-034 Bench SHALL cover: word 5 = 32'h00ff00ff. Required: word_valid and err together with pixel_idx=5, no frame_done, bitmap unchanged.
REQ-035 Bench SHALL cover: sck stopped after pixel 10 for TIMEOUT+1 clk cycles. Required: one err pulse, no further word_valid. The next full frame decodes correctly.
REQ-036 Bench SHALL cover: reset pulsed during pixel 40, then a full frame. Required: outputs 0 after reset, then a single correct frame_done.
